lif_layer_core: RTL and testbench



---
 rtl/snn_pkg.sv | 44 ++++
 rtl/lif_neuron_update.sv | 23 ++
 rtl/lif_layer_core.sv | 147 ++++++++++++++
 tb/tb_lif_layer_core.sv | 191 +++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared defaults, FSM state encoding and arithmetic helpers for the LIF layer.
package snn_pkg;

    localparam int DEF_N_IN    = 4;
    localparam int DEF_N_OUT   = 4;
    localparam int DEF_W_WIDTH = 8;
    localparam int DEF_V_WIDTH = 12;

    typedef enum logic [2:0] {
        IDLE,
        RUN,
        DRAIN,
        FIRE,
        DONE
    } state_t;

    // Operands are at most a few bits wider than V_WIDTH, so the 32-bit sum cannot overflow.
    function automatic logic signed [31:0] sat_add(
        input logic signed [31:0] a,
        input logic signed [31:0] b,
        input int unsigned        width
    );
        logic signed [31:0] sum;
        logic signed [31:0] hi;
        logic signed [31:0] lo;
        sum = a + b;
        hi  = (32'sd1 <<< (width - 1)) - 32'sd1;
        lo  = -(32'sd1 <<< (width - 1));
        if (sum > hi)
            return hi;
        else if (sum < lo)
            return lo;
        return sum;
    endfunction

    function automatic int unsigned compose_addr(
        input int unsigned out_idx,
        input int unsigned in_idx,
        input int unsigned in_bits
    );
        return (out_idx << in_bits) | in_idx;
    endfunction

endpackage

// File: rtl/lif_neuron_update.sv
// Combinational leak, threshold compare and fire-reset for a single neuron.
module lif_neuron_update #(
    parameter int V_WIDTH    = 12,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 3
) (
    input  logic signed [V_WIDTH-1:0] v_in,
    output logic signed [V_WIDTH-1:0] v_out,
    output logic                      spike
);

    localparam logic signed [V_WIDTH-1:0] TH = V_WIDTH'(THRESH);

    logic signed [V_WIDTH-1:0] vl;

    // |v >>> LEAK_SHIFT| <= |v|, so the subtraction stays in range.
    always_comb begin
        vl    = v_in - (v_in >>> LEAK_SHIFT);
        spike = (vl >= TH);
        v_out = spike ? '0 : vl;
    end

endmodule

// File: rtl/lif_layer_core.sv
// N_IN x N_OUT leaky integrate-and-fire layer reading weights from a registered memory.
// Optional LIF_REFRACTORY_EN: a neuron that fires sits out the following timestep.
module lif_layer_core
    import snn_pkg::*;
#(
    parameter int N_IN       = DEF_N_IN,
    parameter int N_OUT      = DEF_N_OUT,
    parameter int W_WIDTH    = DEF_W_WIDTH,
    parameter int V_WIDTH    = DEF_V_WIDTH,
    parameter int THRESH     = 64,
    parameter int LEAK_SHIFT = 3
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            start,
    input  logic [N_IN-1:0]                 spikes_in,
    output logic                            busy,
    output logic                            done,
    output logic [N_OUT-1:0]                spikes_out,
    output logic [$clog2(N_IN*N_OUT)-1:0]   mem_addr,
    output logic                            mem_we,
    input  logic [W_WIDTH-1:0]              mem_rdata
);

    localparam int unsigned IN_BITS  = $clog2(N_IN);
    localparam int unsigned OUT_BITS = $clog2(N_OUT);
    localparam int unsigned ADDR_W   = $clog2(N_IN*N_OUT);

    state_t state, state_nxt;

    logic [IN_BITS-1:0]        in_cnt, rd_in;
    logic [OUT_BITS-1:0]       out_cnt, rd_out;
    logic                      rd_valid;
    logic                      last_addr;
    logic                      acc_en;
    logic [N_IN-1:0]           spk_cap;
    logic signed [V_WIDTH-1:0] v      [N_OUT];
    logic signed [V_WIDTH-1:0] v_leak [N_OUT];
    logic signed [V_WIDTH-1:0] v_fire [N_OUT];
    logic [N_OUT-1:0]          spk_n;
    logic [N_OUT-1:0]          fire_vec;
`ifdef LIF_REFRACTORY_EN
    logic [N_OUT-1:0]          refr;
`endif

    assign last_addr = (in_cnt == IN_BITS'(N_IN - 1)) && (out_cnt == OUT_BITS'(N_OUT - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last_addr) state_nxt = DRAIN;
            DRAIN:   state_nxt = FIRE;
            FIRE:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        busy     = (state == RUN) || (state == DRAIN) || (state == FIRE);
        done     = (state == DONE);
        mem_we   = 1'b0;
        mem_addr = '0;
        if (state == RUN)
            mem_addr = ADDR_W'(compose_addr(32'(out_cnt), 32'(in_cnt), IN_BITS));
    end

    genvar g;
    generate
        for (g = 0; g < N_OUT; g++) begin : g_neuron
            lif_neuron_update #(
                .V_WIDTH    (V_WIDTH),
                .THRESH     (THRESH),
                .LEAK_SHIFT (LEAK_SHIFT)
            ) u_neuron (
                .v_in  (v[g]),
                .v_out (v_leak[g]),
                .spike (spk_n[g])
            );
        end
    endgenerate

    // Refractory neurons hold v = 0 and are masked from firing; refr then follows fire_vec.
    always_comb begin
        acc_en = rd_valid && spk_cap[rd_in];
`ifdef LIF_REFRACTORY_EN
        acc_en = acc_en && !refr[rd_out];
`endif
        for (int unsigned j = 0; j < N_OUT; j++) begin
`ifdef LIF_REFRACTORY_EN
            fire_vec[j] = spk_n[j] & ~refr[j];
            v_fire[j]   = refr[j] ? '0 : v_leak[j];
`else
            fire_vec[j] = spk_n[j];
            v_fire[j]   = v_leak[j];
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            in_cnt     <= '0;
            out_cnt    <= '0;
            rd_in      <= '0;
            rd_out     <= '0;
            rd_valid   <= 1'b0;
            spk_cap    <= '0;
            spikes_out <= '0;
            for (int unsigned j = 0; j < N_OUT; j++)
                v[j] <= '0;
`ifdef LIF_REFRACTORY_EN
            refr       <= '0;
`endif
        end else begin
            state    <= state_nxt;
            rd_valid <= (state == RUN);
            rd_in    <= in_cnt;
            rd_out   <= out_cnt;

            if (state == IDLE && start) begin
                spk_cap <= spikes_in;
                in_cnt  <= '0;
                out_cnt <= '0;
            end else if (state == RUN) begin
                in_cnt <= in_cnt + 1'b1;
                if (in_cnt == IN_BITS'(N_IN - 1))
                    out_cnt <= out_cnt + 1'b1;
            end

            // Read data lags the address by one cycle; rd_in/rd_out track the word in flight.
            if (acc_en)
                v[rd_out] <= V_WIDTH'(sat_add(32'(v[rd_out]), 32'($signed(mem_rdata)), V_WIDTH));

            if (state == FIRE) begin
                for (int unsigned j = 0; j < N_OUT; j++)
                    v[j] <= v_fire[j];
                spikes_out <= fire_vec;
`ifdef LIF_REFRACTORY_EN
                refr       <= fire_vec;
`endif
            end
        end
    end

endmodule

// File: tb/tb_lif_layer_core.sv
// Scoreboard bench for lif_layer_core: expected spike vectors queued at start, checked on done.
module tb_lif_layer_core;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [3:0] spikes_in = '0;
    logic       busy;
    logic       done;
    logic [3:0] spikes_out;
    logic [3:0] mem_addr;
    logic       mem_we;
    logic [7:0] mem_rdata = '0;

    logic [7:0] wmem [16];
    logic [3:0] exp_q [$];
    int         errors = 0;
    int         checks = 0;

    always #5 clk = ~clk;

    always @(posedge clk) mem_rdata <= wmem[mem_addr];

    lif_layer_core #(
        .N_IN       (4),
        .N_OUT      (4),
        .W_WIDTH    (8),
        .V_WIDTH    (12),
        .THRESH     (64),
        .LEAK_SHIFT (3)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .spikes_in  (spikes_in),
        .busy       (busy),
        .done       (done),
        .spikes_out (spikes_out),
        .mem_addr   (mem_addr),
        .mem_we     (mem_we),
        .mem_rdata  (mem_rdata)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every done pops one expected spike vector.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0)
                check("unexpected_done", 32'd1, 32'd0);
            else
                check("spikes_out", 32'(spikes_out), 32'(exp_q.pop_front()));
        end
    end

    task automatic fill(input logic [7:0] w);
        for (int i = 0; i < 16; i++) wmem[i] = w;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst   = 1'b1;
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic step(input logic [3:0] spk, input logic [3:0] exp);
        int n;
        exp_q.push_back(exp);
        @(negedge clk);
        spikes_in = spk;
        start     = 1'b1;
        @(negedge clk);
        start     = 1'b0;
        spikes_in = ~spk;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        if (n >= 40) check("done_timeout", 32'd0, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int seen;
        fill(8'h00);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_spikes_out", 32'(spikes_out), 32'd0);
        check("rst_mem_addr", 32'(mem_addr), 32'd0);
        check("rst_mem_we", 32'(mem_we), 32'd0);

        // Address sequence and latency; extra start pulses during busy/DONE are ignored.
        exp_q.push_back(4'b0000);
        @(negedge clk);
        spikes_in = 4'b1111;
        start     = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            @(negedge clk);
            start = (c == 5 || c == 19);
            if (c <= 16) check("mem_addr", 32'(mem_addr), 32'(c - 1));
            check("mem_we", 32'(mem_we), 32'd0);
            check("busy", 32'(busy), 32'(c >= 1 && c <= 18));
            check("done", 32'(done), 32'(c == 19));
        end
        start = 1'b0;

        do_reset();
        fill(8'h20);
        step(4'b1111, 4'b1111);

        do_reset();
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b0000);
        step(4'b0001, 4'b1111);

        do_reset();
        fill(8'h7F);
`ifdef LIF_REFRACTORY_EN
        step(4'b1111, 4'b1111);
        step(4'b1111, 4'b0000);
        step(4'b1111, 4'b1111);
`else
        step(4'b1111, 4'b1111);
        step(4'b1111, 4'b1111);
        step(4'b1111, 4'b1111);
`endif

        // Reset in RUN cycle 8 must abort the step and clear partial sums.
        do_reset();
        @(negedge clk);
        spikes_in = 4'b1111;
        start     = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (7) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("busy_after_rst", 32'(busy), 32'd0);
        seen = 0;
        repeat (25) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        check("no_done_after_rst", 32'(seen), 32'd0);
        fill(8'h00);
        step(4'b0000, 4'b0000);
        fill(8'h20);
        step(4'b0001, 4'b0000);

        // Per-neuron weights exercise the {out_idx, in_idx} mapping.
        do_reset();
        for (int i = 0; i < 4; i++) begin
            wmem[i]      = 8'h20;
            wmem[4 + i]  = 8'h00;
            wmem[8 + i]  = 8'h00;
            wmem[12 + i] = 8'hF0;
        end
        wmem[11] = 8'h7F;
        step(4'b1000, 4'b0100);
        step(4'b0111, 4'b0001);

        // Negative saturation: a wrapped sum would turn positive and fire.
        do_reset();
        fill(8'h80);
        for (int s = 0; s < 8; s++) step(4'b1111, 4'b0000);

        repeat (2) @(negedge clk);
        check("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
